// File: rtl/mlp_frame_driver.sv
// Stream front/back end for a combinational printed-MLP classifier: assembles
// feature beats into one word, waits out the settle window, scores the class.
module mlp_frame_driver #(
   parameter int FEAT_W = 4,
   parameter int N_FEAT = 4,
   parameter int CLS_W  = 2,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [FEAT_W-1:0]        s_feat,
   input  logic [CLS_W-1:0]         s_label,
   input  logic                     s_last,
   output logic [FEAT_W*N_FEAT-1:0] mlp_inp,
   input  logic [CLS_W-1:0]         mlp_out,
   output logic                     r_valid,
   input  logic                     r_ready,
   output logic [CLS_W-1:0]         r_class,
   output logic                     r_match,
   output logic [CNT_W-1:0]         total_cnt,
   output logic [CNT_W-1:0]         err_cnt,
   output logic                     batch_done
);

   localparam int WORD_W = FEAT_W * N_FEAT;
   localparam int IDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_SETTLE,
      ST_RESULT
   } state_t;

   state_t              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic [SCNT_W-1:0]   scnt_q;
   logic [WORD_W-1:0]   shadow_q;
   logic [WORD_W-1:0]   inp_q;
   logic [CLS_W-1:0]    label_q;
   logic                last_q;
   logic [CLS_W-1:0]    class_q;
   logic                match_q;
   logic [CNT_W-1:0]    total_q;
   logic [CNT_W-1:0]    err_q;
   logic                done_q;
   logic                clr_pend_q;

   logic [WORD_W-1:0]   word_d;
   logic                accept;
   logic                last_beat;
   logic                settle_end;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != {CNT_W{1'b1}}))
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      return v;
   endfunction

   assign s_ready    = rst_n && (state_q == ST_LOAD);
   assign accept     = s_valid && s_ready;
   assign last_beat  = (idx_q == IDX_W'(N_FEAT - 1));
   assign settle_end = (scnt_q == SCNT_W'(SETTLE - 1));

   // Current beat merged into the shadow; on the final beat this is the full word.
   always_comb begin
      word_d = shadow_q;
      word_d[int'(idx_q)*FEAT_W +: FEAT_W] = s_feat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_LOAD;
         idx_q      <= '0;
         scnt_q     <= '0;
         shadow_q   <= '0;
         inp_q      <= '0;
         label_q    <= '0;
         last_q     <= 1'b0;
         class_q    <= '0;
         match_q    <= 1'b0;
         total_q    <= '0;
         err_q      <= '0;
         done_q     <= 1'b0;
         clr_pend_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_LOAD: begin
               if (accept) begin
                  // Counters keep the finished batch visible until the next batch starts.
                  if (clr_pend_q) begin
                     total_q    <= '0;
                     err_q      <= '0;
                     clr_pend_q <= 1'b0;
                  end
                  if (last_beat) begin
                     inp_q   <= word_d;
                     label_q <= s_label;
                     last_q  <= s_last;
                     idx_q   <= '0;
                     scnt_q  <= '0;
                     state_q <= ST_SETTLE;
                  end else begin
                     shadow_q <= word_d;
                     idx_q    <= idx_q + 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               if (settle_end) begin
                  class_q <= mlp_out;
                  match_q <= (mlp_out == label_q);
                  total_q <= sat_inc(total_q, 1'b1);
                  err_q   <= sat_inc(err_q, mlp_out != label_q);
                  state_q <= ST_RESULT;
               end else begin
                  scnt_q <= scnt_q + 1'b1;
               end
            end
            ST_RESULT: begin
               if (r_ready) begin
                  state_q <= ST_LOAD;
                  if (last_q) begin
                     done_q     <= 1'b1;
                     clr_pend_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_LOAD;
         endcase
      end
   end

   assign mlp_inp    = inp_q;
   assign r_valid    = (state_q == ST_RESULT);
   assign r_class    = class_q;
   assign r_match    = match_q;
   assign total_cnt  = total_q;
   assign err_cnt    = err_q;
   assign batch_done = done_q;

endmodule
